audio_channel_q: RTL and testbench
==================================

Name: audio_channel_q

Overview:
Next-generation audio DMA channel. Fetches 32-bit sample words from memory over a request/ready DMA port and buffers them in a word FIFO. On each rising edge of the output sample clock it delivers one left/right frame, scaled by a volume. Adds over the previous channel a parametrised descriptor queue, parametrised FIFO depth and volume width, a loop mode, overflow/underrun flags and queue-level status. One instance sits per mixer input in the audio subsystem.

Parameters:
DESC_DEPTH, 4, descriptor queue entries (power of two, >=2)
FIFO_DEPTH, 8, sample-word FIFO entries (power of two, >=2)
VOLUME_WIDTH, 4, volume bits; unity gain = 2^(VOLUME_WIDTH-1)
COUNT_WIDTH, 24, descriptor word-count width

Ports:
i_clock  in  1  system clock
i_reset  in  1  synchronous, active-low reset
i_dma_setup_request  in  1  one-cycle descriptor strobe
i_dma_setup_append_or_replace  in  1  0 = replace, 1 = append
i_dma_setup_mono_or_stereo  in  1  0 = mono, 1 = stereo
i_dma_setup_loop  in  1  loop this descriptor when the queue runs dry
i_dma_setup_address  in  32  word-aligned start address
i_dma_setup_count  in  COUNT_WIDTH  32-bit words to fetch (0 = ignored)
o_dma_request  out  1  read request
o_dma_address  out  32  read address
i_dma_ready  in  1  read complete; i_dma_rdata valid this cycle
i_dma_rdata  in  32  read data
i_volume  in  VOLUME_WIDTH  output gain
i_output_sample_clock  in  1  sample-rate clock, synchronous to i_clock, high and low each >=2 i_clock cycles
o_output_sample_left  out  16  signed left sample
o_output_sample_right  out  16  signed right sample
o_busy  out  1  descriptor active or queue non-empty
o_queue_level  out  $clog2(DESC_DEPTH)+1  queued descriptors, excluding the active one
o_setup_overflow  out  1  one-cycle pulse: append dropped because the queue is full
o_underrun  out  1  one-cycle pulse: sample edge arrived with FIFO empty

Behaviour:
- Reset, sampled when i_reset==0 at a clock edge: all outputs 0. Queue, FIFO and active descriptor are cleared, FSM goes to IDLE, loop is cleared. Reset mid-transfer abandons the outstanding read, and any later i_dma_ready is ignored.
- Descriptor FSM states:
  - IDLE: when the queue is non-empty, pop the next descriptor into the active registers and go to FETCH.
  - FETCH: when a FIFO slot is free (counting the outstanding read), assert o_dma_request with o_dma_address = current address. Hold both stable until i_dma_ready.
  - On the i_dma_ready cycle: write i_dma_rdata to the FIFO, address += 4, remaining -= 1, drop the request. The next request may be issued the following cycle.
  - When remaining reaches 0: if the queue is non-empty, pop the next descriptor. Otherwise, if loop is set, reload the last descriptor. Otherwise go to IDLE.
  - ABORT: wait for the outstanding i_dma_ready, discard its data, flush the FIFO, then load the replacement descriptor and go to FETCH.
- Append: push to the queue. If the queue is full, drop the descriptor and pulse o_setup_overflow in the following cycle. Append while IDLE with an empty queue starts the fetch within 2 cycles.
- Replace: flush the queue, then push the new descriptor.
  - No read outstanding: flush the FIFO and load the new descriptor next cycle.
  - Read outstanding: go to ABORT.
- count==0 setups are ignored and change no state.
- Setup and i_dma_ready in the same cycle: the data beat is processed first, then the setup.
- Frame unpacking:
  - Stereo: each word gives one frame, left = [15:0], right = [31:16].
  - Mono: each word gives two frames, [15:0] first then [31:16], with left = right.
  - The word is popped from the FIFO after its last frame is consumed.
- Output timing: the sample edge is detected at the first i_clock edge where the clock is high and was low in the previous cycle. Outputs update on the next i_clock edge.
- Underrun: the previous output is held and o_underrun pulses.
- Volume: out = sat16((signed sample × unsigned i_volume) >>> (VOLUME_WIDTH-1)), with an arithmetic shift and saturation to 0x7FFF / 0x8000.

Decomposition:
- Package audio_channel_q_pkg holds:
  - the descriptor struct (address, count, stereo, loop);
  - the FSM state enum (IDLE, FETCH, ABORT);
  - the unity-volume constant function.
- Sub-module audio_channel_q_fifo: parametrised synchronous FIFO (push, pop, full, empty, level), instanced for both the descriptor queue and the sample FIFO.

Test Plan:
- Replace with addr 0xCAFE_0000, count 4, stereo, i_volume = 8 (VOLUME_WIDTH=4), i_dma_rdata = 0x2000_1000 → reads at 0xCAFE_0000..0xCAFE_000C; frames L=0x1000, R=0x2000; o_busy drops after the last read.
- Mono, count 2, rdata 0x0002_0001 then 0x0004_0003 → four frames with L=R = 1, 2, 3, 4 in order.
- Five appends with DESC_DEPTH 4 while a descriptor is active → o_queue_level = 4 and o_setup_overflow pulses once. Descriptors run back-to-back with contiguous address sequences.
- Replace to 0x3333_0000 while a read is pending with ready delayed 5 cycles → the pending data is discarded and the next request address is 0x3333_0000.
- Loop set, count 2, no further setups → the address sequence repeats base, base+4, base, base+4...
- rdata 0x7000_7000 with i_volume 15 → outputs saturate to 0x7FFF. Stop the DMA ready and keep the sample clock running → o_underrun pulses and the outputs are held.

Source files
------------

// File: rtl/audio_channel_q_pkg.sv
// audio_channel_q_pkg: shared types and helpers for the audio DMA channel
package audio_channel_q_pkg;
  typedef enum logic [1:0] {IDLE, FETCH, ABORT} state_e;
  typedef struct packed {
    logic [31:0] address;
    logic [31:0] count;
    logic        stereo;
    logic        loop;
  } desc_t;
  function automatic int unity_volume(input int width);
    return 1 << (width - 1);
  endfunction
endpackage

// File: rtl/audio_channel_q_fifo.sv
// audio_channel_q_fifo: synchronous FIFO with flush; flush together with push leaves only the pushed entry
// ports: i_clock/i_reset (sync, active-low), i_flush, i_push/i_wdata, i_pop/o_rdata, o_full, o_empty, o_level
module audio_channel_q_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  input  logic                   i_flush,
  input  logic                   i_push,
  input  logic [WIDTH-1:0]       i_wdata,
  input  logic                   i_pop,
  output logic [WIDTH-1:0]       o_rdata,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_level
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] rd_q, wr_q;
  logic [AW:0] cnt_q;
  logic do_push, do_pop;
  always_comb begin
    do_push = i_push && (i_flush || !o_full);
    do_pop  = i_pop && !o_empty && !i_flush;
  end
  assign o_full  = cnt_q == (AW+1)'(DEPTH);
  assign o_empty = cnt_q == '0;
  assign o_level = cnt_q;
  assign o_rdata = mem_q[rd_q];
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else if (i_flush) begin
      rd_q  <= '0;
      wr_q  <= AW'(i_push);
      cnt_q <= (AW+1)'(i_push);
    end else begin
      rd_q  <= rd_q + AW'(do_pop);
      wr_q  <= wr_q + AW'(do_push);
      cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
  always_ff @(posedge i_clock)
    if (do_push) mem_q[i_flush ? '0 : wr_q] <= i_wdata;
endmodule

// File: rtl/audio_channel_q.sv
// audio_channel_q: descriptor-queued audio DMA channel delivering volume-scaled L/R frames per sample-clock edge
// ports: i_clock/i_reset (sync, active-low); i_dma_setup_* descriptor strobe; o_dma_request/o_dma_address,
//        i_dma_ready/i_dma_rdata read port; i_volume, i_output_sample_clock -> o_output_sample_left/right;
//        o_busy, o_queue_level, o_setup_overflow, o_underrun status
module audio_channel_q
  import audio_channel_q_pkg::*;
#(
  parameter int DESC_DEPTH   = 4,
  parameter int FIFO_DEPTH   = 8,
  parameter int VOLUME_WIDTH = 4,
  parameter int COUNT_WIDTH  = 24
) (
  input  logic                          i_clock,
  input  logic                          i_reset,
  input  logic                          i_dma_setup_request,
  input  logic                          i_dma_setup_append_or_replace,
  input  logic                          i_dma_setup_mono_or_stereo,
  input  logic                          i_dma_setup_loop,
  input  logic [31:0]                   i_dma_setup_address,
  input  logic [COUNT_WIDTH-1:0]        i_dma_setup_count,
  output logic                          o_dma_request,
  output logic [31:0]                   o_dma_address,
  input  logic                          i_dma_ready,
  input  logic [31:0]                   i_dma_rdata,
  input  logic [VOLUME_WIDTH-1:0]       i_volume,
  input  logic                          i_output_sample_clock,
  output logic [15:0]                   o_output_sample_left,
  output logic [15:0]                   o_output_sample_right,
  output logic                          o_busy,
  output logic [$clog2(DESC_DEPTH):0]   o_queue_level,
  output logic                          o_setup_overflow,
  output logic                          o_underrun
);
  localparam int SW = $clog2(FIFO_DEPTH) + 1;
  state_e state_q, state_d;
  logic [31:0] addr_q, addr_d, rem_q, rem_d, base_addr_q, base_addr_d, base_cnt_q, base_cnt_d;
  logic stereo_q, stereo_d, loop_q, loop_d, req_q, req_d, ovf_q, ovf_d;
  logic sclk_q, edge_q, half_q, half_d, und_q, und_d;
  logic [15:0] left_q, left_d, right_q, right_d, lo_s, hi_s;
  desc_t setup_desc, q_head, nd;
  logic q_push, q_pop, q_flush, q_full, q_empty;
  logic s_push, s_pop, s_flush, s_full, s_empty;
  logic [32:0] s_rdata;
  logic [SW-1:0] s_level;
  logic beat, setup_v, ld;
  audio_channel_q_fifo #(.WIDTH($bits(desc_t)), .DEPTH(DESC_DEPTH)) u_queue (
    .i_clock(i_clock), .i_reset(i_reset), .i_flush(q_flush), .i_push(q_push), .i_wdata(setup_desc),
    .i_pop(q_pop), .o_rdata(q_head), .o_full(q_full), .o_empty(q_empty), .o_level(o_queue_level)
  );
  // each word carries the stereo flag of the descriptor that fetched it
  audio_channel_q_fifo #(.WIDTH(33), .DEPTH(FIFO_DEPTH)) u_samples (
    .i_clock(i_clock), .i_reset(i_reset), .i_flush(s_flush), .i_push(s_push), .i_wdata({stereo_q, i_dma_rdata}),
    .i_pop(s_pop), .o_rdata(s_rdata), .o_full(s_full), .o_empty(s_empty), .o_level(s_level)
  );
  function automatic logic [15:0] scale(input logic [15:0] s, input logic [VOLUME_WIDTH-1:0] v);
    logic signed [16+VOLUME_WIDTH:0] p;
    p = ($signed(s) * $signed({1'b0, v})) >>> (VOLUME_WIDTH - 1);
    return p > 32767 ? 16'h7fff : p < -32768 ? 16'h8000 : p[15:0];
  endfunction
  always_comb begin
    setup_desc = '{address: i_dma_setup_address, count: 32'(i_dma_setup_count),
                   stereo: i_dma_setup_mono_or_stereo, loop: i_dma_setup_loop};
    beat    = i_dma_ready && req_q;
    setup_v = i_dma_setup_request && (i_dma_setup_count != '0);
    state_d = state_q;
    addr_d = addr_q;
    rem_d = rem_q;
    base_addr_d = base_addr_q;
    base_cnt_d = base_cnt_q;
    stereo_d = stereo_q;
    loop_d = loop_q;
    req_d = req_q;
    ovf_d = 1'b0;
    q_push = 1'b0;
    q_pop = 1'b0;
    q_flush = 1'b0;
    s_push = 1'b0;
    s_flush = 1'b0;
    ld = 1'b0;
    nd = q_head;
    if (beat) begin
      req_d = 1'b0;
      if (state_q == ABORT) begin
        s_flush = 1'b1;
        q_pop = 1'b1;
        ld = 1'b1;
      end else begin
        s_push = !s_full;
        addr_d = addr_q + 32'd4;
        rem_d = rem_q - 32'd1;
      end
    end else if (state_q == IDLE && !q_empty) begin
      q_pop = 1'b1;
      ld = 1'b1;
    end else if (state_q == FETCH && !req_q) begin
      if (rem_q == '0) begin
        if (!q_empty) begin
          q_pop = 1'b1;
          ld = 1'b1;
        end else if (loop_q) begin
          ld = 1'b1;
          nd = '{address: base_addr_q, count: base_cnt_q, stereo: stereo_q, loop: 1'b1};
        end else state_d = IDLE;
      end else if (s_level < SW'(FIFO_DEPTH)) req_d = 1'b1;
    end
    // setup is applied after the data beat so it can override it
    if (setup_v) begin
      if (i_dma_setup_append_or_replace) begin
        ovf_d = q_full;
        q_push = !q_full;
      end else if (req_q && !beat) begin
        q_flush = 1'b1;
        q_push = 1'b1;
        q_pop = 1'b0;
        state_d = ABORT;
      end else begin
        q_flush = 1'b1;
        q_pop = 1'b0;
        s_flush = 1'b1;
        s_push = 1'b0;
        ld = 1'b1;
        nd = setup_desc;
      end
    end
    if (ld) begin
      addr_d = nd.address;
      rem_d = nd.count;
      base_addr_d = nd.address;
      base_cnt_d = nd.count;
      stereo_d = nd.stereo;
      loop_d = nd.loop;
      state_d = FETCH;
    end
  end
  always_comb begin
    lo_s = (s_rdata[32] || !half_q) ? s_rdata[15:0] : s_rdata[31:16];
    hi_s = s_rdata[32] ? s_rdata[31:16] : lo_s;
    left_d = left_q;
    right_d = right_q;
    und_d = 1'b0;
    s_pop = 1'b0;
    half_d = half_q;
    if (edge_q) begin
      if (s_empty) und_d = 1'b1;
      else begin
        left_d = scale(lo_s, i_volume);
        right_d = scale(hi_s, i_volume);
        s_pop = s_rdata[32] || half_q;
        half_d = !s_rdata[32] && !half_q;
      end
    end
    if (s_flush) half_d = 1'b0;
  end
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      state_q <= IDLE;
      addr_q <= '0;
      rem_q <= '0;
      base_addr_q <= '0;
      base_cnt_q <= '0;
      stereo_q <= 1'b0;
      loop_q <= 1'b0;
      req_q <= 1'b0;
      ovf_q <= 1'b0;
      sclk_q <= 1'b0;
      edge_q <= 1'b0;
      half_q <= 1'b0;
      und_q <= 1'b0;
      left_q <= '0;
      right_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      rem_q <= rem_d;
      base_addr_q <= base_addr_d;
      base_cnt_q <= base_cnt_d;
      stereo_q <= stereo_d;
      loop_q <= loop_d;
      req_q <= req_d;
      ovf_q <= ovf_d;
      sclk_q <= i_output_sample_clock;
      edge_q <= i_output_sample_clock && !sclk_q;
      half_q <= half_d;
      und_q <= und_d;
      left_q <= left_d;
      right_q <= right_d;
    end
  end
  assign o_dma_request = req_q;
  assign o_dma_address = addr_q;
  assign o_output_sample_left = left_q;
  assign o_output_sample_right = right_q;
  assign o_busy = state_q != IDLE || !q_empty;
  assign o_setup_overflow = ovf_q;
  assign o_underrun = und_q;
endmodule

// File: tb/tb_audio_channel_q.sv
// tb_audio_channel_q: directed, table-driven self-checking bench for audio_channel_q
module tb_audio_channel_q;
  import audio_channel_q_pkg::*;
  logic clk = 1'b0, rst_n, setup_req, aor, mos, lp, dma_req, dma_ready, sclk, busy, ovf, und;
  logic [31:0] saddr, dma_addr, dma_rdata, rdata_val, pend;
  logic [23:0] scount;
  logic [3:0] vol;
  logic [15:0] left, right, l, r;
  logic [2:0] qlvl;
  logic u, ready_en, gen, force_ready;
  int lat, wcnt, base, ob, passed = 0, total = 0, ovf_cnt = 0;
  logic [31:0] log_q [$];
  typedef struct {logic [31:0] rdata; logic [3:0] vol; logic [15:0] l, r;} vec_t;
  vec_t vecs [8];
  logic [31:0] qexp [6];

  audio_channel_q dut (
    .i_clock(clk), .i_reset(rst_n), .i_dma_setup_request(setup_req), .i_dma_setup_append_or_replace(aor),
    .i_dma_setup_mono_or_stereo(mos), .i_dma_setup_loop(lp), .i_dma_setup_address(saddr),
    .i_dma_setup_count(scount), .o_dma_request(dma_req), .o_dma_address(dma_addr), .i_dma_ready(dma_ready),
    .i_dma_rdata(dma_rdata), .i_volume(vol), .i_output_sample_clock(sclk), .o_output_sample_left(left),
    .o_output_sample_right(right), .o_busy(busy), .o_queue_level(qlvl), .o_setup_overflow(ovf),
    .o_underrun(und)
  );

  always #5 clk = ~clk;
  always @(negedge clk) if (ovf) ovf_cnt <= ovf_cnt + 1;

  function automatic logic [31:0] gen_word(input logic [31:0] a);
    int k;
    k = int'(a[5:2]);
    return {16'(2 * k + 2), 16'(2 * k + 1)};
  endfunction

  // memory model: answers a request after lat idle cycles, data latched when the request is first seen
  initial begin
    wcnt = 0;
    dma_ready = 1'b0;
    dma_rdata = '0;
    forever begin
      @(negedge clk);
      dma_ready = 1'b0;
      if (!rst_n) wcnt = 0;
      else if (force_ready) begin
        dma_ready = 1'b1;
        dma_rdata = 32'hDEAD_BEEF;
      end else if (ready_en && dma_req) begin
        if (wcnt == 0) pend = gen ? gen_word(dma_addr) : rdata_val;
        if (wcnt >= lat) begin
          dma_ready = 1'b1;
          dma_rdata = pend;
          log_q.push_back(dma_addr);
          wcnt = 0;
        end else wcnt++;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic setup(input logic app, input logic st, input logic lo, input logic [31:0] a, input logic [23:0] c);
    @(negedge clk);
    setup_req = 1'b1; aor = app; mos = st; lp = lo; saddr = a; scount = c;
    @(negedge clk);
    setup_req = 1'b0;
  endtask

  task automatic frame(output logic [15:0] fl, output logic [15:0] fr, output logic fu);
    @(negedge clk) sclk = 1'b1;
    @(negedge clk);
    @(negedge clk);
    fl = left; fr = right; fu = und;
    @(negedge clk) sclk = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk(name, busy, 0);
  endtask

  task automatic wait_req(input string name);
    int n = 0;
    while (!dma_req && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk(name, dma_req, 1);
  endtask

  initial begin
    vecs[0] = '{32'h2000_1000, 4'd8,  16'h1000, 16'h2000};
    vecs[1] = '{32'h7000_7000, 4'd15, 16'h7FFF, 16'h7FFF};
    vecs[2] = '{32'h9000_9000, 4'd15, 16'h8000, 16'h8000};
    vecs[3] = '{32'hFFFF_0001, 4'd8,  16'h0001, 16'hFFFF};
    vecs[4] = '{32'hFFFD_0003, 4'd4,  16'h0001, 16'hFFFE};
    vecs[5] = '{32'h4000_C000, 4'd0,  16'h0000, 16'h0000};
    vecs[6] = '{32'h8000_7FFF, 4'd8,  16'h7FFF, 16'h8000};
    vecs[7] = '{32'h8000_0100, 4'd9,  16'h0120, 16'h8000};
    qexp = '{32'h1000, 32'h1004, 32'h2000, 32'h3000, 32'h4000, 32'h5000};
    rst_n = 1'b0; setup_req = 1'b0; aor = 1'b0; mos = 1'b0; lp = 1'b0; saddr = '0; scount = '0;
    vol = 4'(unity_volume(4)); sclk = 1'b0; ready_en = 1'b1; gen = 1'b0; force_ready = 1'b0;
    lat = 0; rdata_val = '0;
    repeat (3) @(negedge clk);
    chk("rst_req", dma_req, 0);
    chk("rst_addr", dma_addr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_level", qlvl, 0);
    chk("rst_out", {left, right}, 0);
    chk("rst_flags", {ovf, und}, 0);
    rst_n = 1'b1;

    // stereo replace, four reads, then underrun holds the last frame
    base = log_q.size();
    rdata_val = 32'h2000_1000;
    setup(1'b0, 1'b1, 1'b0, 32'hCAFE_0000, 24'd4);
    chk("st_busy", busy, 1);
    wait_idle("st_idle");
    chk("st_nreads", 32'(log_q.size() - base), 4);
    for (int i = 0; i < 4; i++) chk($sformatf("st_addr%0d", i), log_q[base + i], 32'hCAFE_0000 + 32'(4 * i));
    for (int i = 0; i < 4; i++) begin
      frame(l, r, u);
      chk($sformatf("st_frame%0d", i), {l, r, 15'd0, u}, {16'h1000, 16'h2000, 16'd0});
    end
    frame(l, r, u);
    chk("st_underrun", u, 1);
    chk("st_hold", {l, r}, {16'h1000, 16'h2000});

    // mono unpacking
    gen = 1'b1;
    setup(1'b0, 1'b0, 1'b0, 32'h0, 24'd2);
    wait_idle("mono_idle");
    for (int i = 0; i < 4; i++) begin
      frame(l, r, u);
      chk($sformatf("mono_frame%0d", i), {l, r}, {16'(i + 1), 16'(i + 1)});
    end
    gen = 1'b0;

    // volume scaling / saturation table
    for (int i = 0; i < 8; i++) begin
      rdata_val = vecs[i].rdata;
      vol = vecs[i].vol;
      setup(1'b0, 1'b1, 1'b0, 32'h5000_0000, 24'd1);
      wait_idle("vec_idle");
      frame(l, r, u);
      chk($sformatf("vec%0d", i), {l, r}, {vecs[i].l, vecs[i].r});
    end
    vol = 4'(unity_volume(4));

    // queue fill and overflow
    rdata_val = 32'h0;
    lat = 10;
    base = log_q.size();
    ob = ovf_cnt;
    setup(1'b0, 1'b1, 1'b0, 32'h1000, 24'd2);
    for (int i = 0; i < 5; i++) setup(1'b1, 1'b1, 1'b0, 32'h2000 + 32'(32'h1000 * i), 24'd1);
    chk("q_level_full", qlvl, 4);
    lat = 0;
    wait_idle("q_idle");
    chk("q_ovf_pulses", 32'(ovf_cnt - ob), 1);
    chk("q_level_end", qlvl, 0);
    chk("q_nreads", 32'(log_q.size() - base), 6);
    for (int i = 0; i < 6; i++) chk($sformatf("q_addr%0d", i), log_q[base + i], qexp[i]);

    // replace while a read is outstanding
    rdata_val = 32'h1111_1111;
    lat = 5;
    base = log_q.size();
    setup(1'b0, 1'b1, 1'b0, 32'h1110_0000, 24'd4);
    wait_req("ab_req");
    @(negedge clk);
    rdata_val = 32'h3333_3333;
    setup(1'b0, 1'b1, 1'b0, 32'h3333_0000, 24'd1);
    chk("ab_hold", {31'd0, dma_req}, 1);
    chk("ab_hold_addr", dma_addr, 32'h1110_0000);
    wait_idle("ab_idle");
    chk("ab_nreads", 32'(log_q.size() - base), 2);
    chk("ab_addr0", log_q[base], 32'h1110_0000);
    chk("ab_addr1", log_q[base + 1], 32'h3333_0000);
    frame(l, r, u);
    chk("ab_frame", {l, r}, {16'h3333, 16'h3333});
    frame(l, r, u);
    chk("ab_underrun", u, 1);
    lat = 0;

    // loop mode repeats the descriptor until the FIFO fills
    rdata_val = 32'h0100_0100;
    base = log_q.size();
    setup(1'b0, 1'b1, 1'b1, 32'h4440_0000, 24'd2);
    repeat (40) @(negedge clk);
    chk("loop_nreads", 32'(log_q.size() - base), 8);
    for (int i = 0; i < 8; i++) chk($sformatf("loop_addr%0d", i), log_q[base + i], 32'h4440_0000 + 32'(4 * (i % 2)));
    chk("loop_busy", busy, 1);

    // saturation, then DMA stopped: underrun holds the saturated output
    vol = 4'd15;
    rdata_val = 32'h7000_7000;
    setup(1'b0, 1'b1, 1'b0, 32'h6000_0000, 24'd2);
    wait_idle("sat_idle");
    ready_en = 1'b0;
    for (int i = 0; i < 2; i++) begin
      frame(l, r, u);
      chk($sformatf("sat_frame%0d", i), {l, r, 15'd0, u}, {16'h7FFF, 16'h7FFF, 16'd0});
    end
    frame(l, r, u);
    chk("sat_underrun", u, 1);
    chk("sat_hold", {l, r}, {16'h7FFF, 16'h7FFF});
    chk("sat_underrun_pulse", und, 0);
    ready_en = 1'b1;

    // reset mid-transfer; the late ready is ignored
    vol = 4'd8;
    lat = 20;
    setup(1'b0, 1'b1, 1'b0, 32'h7770_0000, 24'd2);
    wait_req("rs_req");
    @(negedge clk) rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rs_out", {dma_req, busy, ovf, und, qlvl}, 0);
    chk("rs_addr", dma_addr, 0);
    chk("rs_samples", {left, right}, 0);
    rst_n = 1'b1;
    force_ready = 1'b1;
    repeat (2) @(negedge clk);
    force_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rs_late_ready", {dma_req, busy, qlvl}, 0);
    frame(l, r, u);
    chk("rs_underrun", u, 1);
    chk("rs_frame", {l, r}, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
